vga_plot_arbiter: RTL
=====================

# vga_plot_arbiter

Shares the single pixel-write port of the VGA adapter between several drawing engines: fillscreen, circle, reuleaux and future engines. Each engine has a requester-side req/ack pair. The arbiter picks one engine round-robin and runs it through the engine start/done handshake. While that engine owns the port, only its plot stream reaches the adapter; all others are blocked. It sits between the engines and the `vga_adapter` instance in each task top level.

## Interface
Parameters:
- NREQ, 3, number of engines/requesters (2..8)

Ports:
- clk  in  1  CLOCK_50 domain clock
- rst_n  in  1  reset, asynchronous, active-low (driven from KEY[3])
- req  in  NREQ  requester i wants engine i run; held until ack[i]
- ack  out  NREQ  one-cycle pulse: engine i job complete
- start_o  out  NREQ  start to engine i; level, held until done
- done_i  in  NREQ  done from engine i; level, held until start drops
- eng_x  in  NREQ×8  engine x coordinate
- eng_y  in  NREQ×7  engine y coordinate
- eng_colour  in  NREQ×3  engine colour
- eng_plot  in  NREQ  engine plot strobe
- vga_x  out  8  to adapter
- vga_y  out  7  to adapter
- vga_colour  out  3  to adapter
- vga_plot  out  1  to adapter
- grant  out  NREQ  one-hot owner; all-zero when idle
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - if req≠0, pick winner w by round-robin: search from (last+1) mod NREQ upward.
  - register grant=onehot(w) and start_o[w]=1; go RUN.
- RUN:
  - start_o[w] stays 1.
  - when done_i[w]=1: start_o[w]←0 and go DRAIN.
- DRAIN:
  - wait done_i[w]=0.
  - then ack[w]←1 for one cycle, grant←0, last←w, go IDLE.
- done_i and eng_plot of non-owners are ignored in all states.
- req of non-owners may change freely; only the req value sampled in IDLE matters.
- A requester must drop req on the edge that ends its ack cycle.
- Pixel path, registered:
  - vga_x/y/colour ← eng_*[w] every cycle while grant≠0; they hold their value otherwise.
  - vga_plot ← (state==RUN) & eng_plot[w] & (eng_x[w]<160) & (eng_y[w]<120).
  - Out-of-screen plots are dropped silently.
  - Plots during DRAIN or IDLE are suppressed.
- Reset values:
  - state=IDLE, last=NREQ-1 (client 0 wins first).
  - grant, start_o, ack, busy, vga_x, vga_y, vga_colour and vga_plot all 0.
- Reset mid-job: all outputs clear immediately (async), start_o drops, and the engine's own rst_n restarts it. There is no resume.

## Timing
- req[i] seen high in IDLE at edge t → grant and start_o[i] high after edge t; busy high from the same edge.
- done_i[w] high at edge t → start_o[w] low after t.
- done_i[w] low at edge t → ack[w] high for cycle t..t+1, then IDLE.
- Minimum turnaround between two jobs: one IDLE cycle after ack.
- Pixel latency: 1 cycle from eng_plot[w] to vga_plot.
- done_i[w] already high on entry to RUN (engine misbehaving): still requires one RUN cycle, then DRAIN.
- Simultaneous requests: at most one grant per IDLE cycle. Losers wait; no request is lost while held.
- Fairness: with all requests held, each client is served within NREQ jobs.

## Structure
- Package vga_arb_pkg holds:
  - XW=8, YW=7, CW=3
  - SCREEN_W=160, SCREEN_H=120
  - state enum arb_state_t {IDLE, RUN, DRAIN}
- One sub-module, rr_pick: combinational; takes req and last, outputs one-hot winner and valid.
- The state machine and output registers live in vga_plot_arbiter.

## Test plan
- Reset then single req[0] with fillscreen-style model (done after 19200 plots) → start_o=001 one cycle later; 19200 vga_plot pulses each 1 cycle after eng_plot; ack[0] pulse; grant returns to 000.
- req=111 held continuously, each model done after 10 plots → service order 0,1,2,0,1,2; never two grant bits set; at least one idle cycle between ack and next start_o.
- Owner 1 plots (159,119) and (160,5) and (3,120) → only (159,119) reaches vga_plot; others dropped.
- Non-owner asserts eng_plot and done_i during client 0's job → no vga_plot from it; client 0's job unaffected.
- rst_n pulsed low mid-RUN → start_o, grant, vga_plot 0 in the same cycle; after release, pending req[2] with last=NREQ-1 order → client 0 first if req[0] also high.
- Engine holds done_i high 5 cycles after start_o drops → arbiter stays in DRAIN; ack exactly one cycle after done_i falls.

Source files
------------

// File: rtl/vga_arb_pkg.sv
// rtl/vga_arb_pkg.sv - shared widths, screen bounds and arbiter state type
package vga_arb_pkg;

  localparam int XW       = 8;
  localparam int YW       = 7;
  localparam int CW       = 3;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } arb_state_t;

endpackage

// File: rtl/vga_plot_arbiter_rr_pick.sv
// rtl/vga_plot_arbiter_rr_pick.sv - combinational round-robin winner select
module rr_pick #(
  parameter int NREQ = 3,
  parameter int LW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   last,
  output logic [NREQ-1:0] winner,
  output logic            valid
);

  // Distance of client i from the slot just after the last winner.
  function automatic int rr_dist(input int i, input logic [LW-1:0] l);
    return (i + NREQ - 1 - int'(l)) % NREQ;
  endfunction

  int best;
  int sel;

  // Requesting client closest to last+1 (wrapping) wins.
  always_comb begin
    best   = NREQ;
    sel    = 0;
    winner = '0;
    valid  = |req;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && (rr_dist(i, last) < best)) begin
        best = rr_dist(i, last);
        sel  = i;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      winner[i] = valid && (sel == i);
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// rtl/vga_plot_arbiter.sv - round-robin owner of the VGA adapter pixel-write port
module vga_plot_arbiter
  import vga_arb_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   start_o,
  input  logic [NREQ-1:0]   done_i,
  input  logic [NREQ*XW-1:0] eng_x,
  input  logic [NREQ*YW-1:0] eng_y,
  input  logic [NREQ*CW-1:0] eng_colour,
  input  logic [NREQ-1:0]   eng_plot,
  output logic [XW-1:0]     vga_x,
  output logic [YW-1:0]     vga_y,
  output logic [CW-1:0]     vga_colour,
  output logic              vga_plot,
  output logic [NREQ-1:0]   grant,
  output logic              busy
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t      state, state_d;
  logic [LW-1:0]   last, last_d;
  logic [LW-1:0]   own, own_d;
  logic [LW-1:0]   pick_idx;
  logic [NREQ-1:0] grant_d, start_d, ack_d;
  logic [NREQ-1:0] pick;
  logic            pick_valid;

  logic [XW-1:0]   own_x;
  logic [YW-1:0]   own_y;
  logic [CW-1:0]   own_colour;
  logic            own_plot;
  logic            own_done;

  rr_pick #(
    .NREQ(NREQ),
    .LW  (LW)
  ) u_rr_pick (
    .req   (req),
    .last  (last),
    .winner(pick),
    .valid (pick_valid)
  );

  // Encode the one-hot winner to an index for the owner register.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) pick_idx = LW'(i);
    end
  end

  // Select the owning engine's pixel stream and done level.
  always_comb begin
    own_x      = '0;
    own_y      = '0;
    own_colour = '0;
    own_plot   = 1'b0;
    own_done   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (LW'(i) == own) begin
        own_x      = eng_x[i*XW +: XW];
        own_y      = eng_y[i*YW +: YW];
        own_colour = eng_colour[i*CW +: CW];
        own_plot   = eng_plot[i];
        own_done   = done_i[i];
      end
    end
  end

  // Next state and next output values; the ack cycle itself is the turnaround IDLE cycle.
  always_comb begin
    state_d = state;
    last_d  = last;
    own_d   = own;
    grant_d = grant;
    start_d = start_o;
    ack_d   = '0;
    case (state)
      IDLE: begin
        if (pick_valid && (ack == '0)) begin
          grant_d = pick;
          start_d = pick;
          own_d   = pick_idx;
          state_d = RUN;
        end
      end
      RUN: begin
        if (own_done) begin
          start_d = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!own_done) begin
          ack_d   = grant;
          grant_d = '0;
          last_d  = own;
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        start_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and handshake registers; last starts at NREQ-1 so client 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= LW'(NREQ - 1);
      own     <= '0;
      grant   <= '0;
      start_o <= '0;
      ack     <= '0;
    end else begin
      state   <= state_d;
      last    <= last_d;
      own     <= own_d;
      grant   <= grant_d;
      start_o <= start_d;
      ack     <= ack_d;
    end
  end

  // Registered pixel path: coordinates follow the owner, plot only in RUN and on-screen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      if (grant != '0) begin
        vga_x      <= own_x;
        vga_y      <= own_y;
        vga_colour <= own_colour;
      end
      vga_plot <= (state == RUN) && own_plot &&
                  (own_x < XW'(SCREEN_W)) && (own_y < YW'(SCREEN_H));
    end
  end

  assign busy = (state != IDLE);

endmodule
